// File: rtl/pipe_forward_chain_pkg.sv
// Shared definitions for the post-decode forwarding chain: default widths,
// the hard-wired zero register and the stage entry layout.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_STAGES   = 3;
    localparam int unsigned DEF_NREAD    = 2;
    localparam int unsigned DEF_LATE_STG = 1;

    // Writes to this register are architecturally discarded and never forward.
    localparam int unsigned ZERO_REG = 0;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
        logic                  rdy;
    } entry_t;

endpackage

// File: rtl/pipe_forward_chain_entry_reg.sv
// One stage register of the forwarding chain: advance, whole-chain hold,
// per-stage flush and optional capture of a late (load) result on entry.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          CAPTURE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              src_valid,
    input  logic              src_we,
    input  logic [ADDR_W-1:0] src_rd,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_rdy,
    input  logic [DATA_W-1:0] late_data,
    output logic              valid,
    output logic              we,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] data,
    output logic              rdy
);

    // Flush only clears valid and beats hold; the payload is left in place
    // because a killed entry can never hit or write back.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            we    <= 1'b0;
            rd    <= '0;
            data  <= '0;
            rdy   <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= src_valid;
            we    <= src_we;
            rd    <= src_rd;
            if (CAPTURE && !src_rdy) begin
                data <= late_data;
                rdy  <= 1'b1;
            end else begin
                data <= src_data;
                rdy  <= src_rdy;
            end
        end
    end

endmodule

// File: rtl/pipe_forward_chain.sv
// Post-decode write-intent chain with youngest-first operand forwarding,
// per-stage flush, whole-chain hold and late load-result capture.
module pipe_forward_chain
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned STAGES   = DEF_STAGES,
    parameter int unsigned NREAD    = DEF_NREAD,
    parameter int unsigned LATE_STG = DEF_LATE_STG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic                     in_valid,
    input  logic                     in_we,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_rdy,
    input  logic [DATA_W-1:0]        late_data,
    input  logic [STAGES-1:0]        flush_vec,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD-1:0]         fwd_hit,
    output logic [NREAD*DATA_W-1:0]  fwd_data,
    output logic [NREAD-1:0]         fwd_stall,
    output logic                     wb_valid,
    output logic                     wb_we,
    output logic [ADDR_W-1:0]        wb_rd,
    output logic [DATA_W-1:0]        wb_data
);

    if (STAGES < 2) begin : g_bad_stages
        $error("pipe_forward_chain: STAGES must be at least 2");
    end
    if (LATE_STG < 1 || LATE_STG > STAGES - 1) begin : g_bad_late
        $error("pipe_forward_chain: LATE_STG must lie in 1..STAGES-1");
    end

    logic              stg_valid [STAGES];
    logic              stg_we    [STAGES];
    logic [ADDR_W-1:0] stg_rd    [STAGES];
    logic [DATA_W-1:0] stg_data  [STAGES];
    logic              stg_rdy   [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic              src_valid;
        logic              src_we;
        logic [ADDR_W-1:0] src_rd;
        logic [DATA_W-1:0] src_data;
        logic              src_rdy;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_we    = in_we;
            assign src_rd    = in_rd;
            assign src_data  = in_data;
            assign src_rdy   = in_rdy;
        end else begin : g_link
            assign src_valid = stg_valid[i-1];
            assign src_we    = stg_we[i-1];
            assign src_rd    = stg_rd[i-1];
            assign src_data  = stg_data[i-1];
            assign src_rdy   = stg_rdy[i-1];
        end

        pipe_entry_reg #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .CAPTURE (i == LATE_STG)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .hold      (hold),
            .flush     (flush_vec[i]),
            .src_valid (src_valid),
            .src_we    (src_we),
            .src_rd    (src_rd),
            .src_data  (src_data),
            .src_rdy   (src_rdy),
            .late_data (late_data),
            .valid     (stg_valid[i]),
            .we        (stg_we[i]),
            .rd        (stg_rd[i]),
            .data      (stg_data[i]),
            .rdy       (stg_rdy[i])
        );
    end

    // Scan oldest to youngest so the last match written is the youngest writer.
    always_comb begin
        logic [ADDR_W-1:0] port_addr;
        int unsigned       idx;
        fwd_hit   = '0;
        fwd_data  = '0;
        fwd_stall = '0;
        port_addr = '0;
        idx       = 0;
        for (int unsigned j = 0; j < NREAD; j++) begin
            port_addr = raddr[j*ADDR_W +: ADDR_W];
            for (int unsigned k = 0; k < STAGES; k++) begin
                idx = STAGES - 1 - k;
                if (stg_valid[idx] && stg_we[idx] &&
                    stg_rd[idx] == port_addr &&
                    stg_rd[idx] != ADDR_W'(ZERO_REG)) begin
                    fwd_hit[j]                  = 1'b1;
                    fwd_data[j*DATA_W +: DATA_W] = stg_data[idx];
                    fwd_stall[j]                = ~stg_rdy[idx];
                end
            end
        end
    end

    assign wb_valid = stg_valid[STAGES-1];
    assign wb_we    = stg_valid[STAGES-1] & stg_we[STAGES-1];
    assign wb_rd    = stg_rd[STAGES-1];
    assign wb_data  = stg_data[STAGES-1];

endmodule

// File: tb/tb_pipe_forward_chain.sv
// Directed bench for pipe_forward_chain: retiring entries are scoreboarded,
// forwarding lookups are compared against hand-computed values.
module tb_pipe_forward_chain;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned STAGES   = 3;
    localparam int unsigned NREAD    = 2;
    localparam int unsigned LATE_STG = 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    hold = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_we = 1'b0;
    logic [ADDR_W-1:0]       in_rd = '0;
    logic [DATA_W-1:0]       in_data = '0;
    logic                    in_rdy = 1'b0;
    logic [DATA_W-1:0]       late_data = '0;
    logic [STAGES-1:0]       flush_vec = '0;
    logic [NREAD*ADDR_W-1:0] raddr = '0;
    logic [NREAD-1:0]        fwd_hit;
    logic [NREAD*DATA_W-1:0] fwd_data;
    logic [NREAD-1:0]        fwd_stall;
    logic                    wb_valid;
    logic                    wb_we;
    logic [ADDR_W-1:0]       wb_rd;
    logic [DATA_W-1:0]       wb_data;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              we;
    } wb_exp_t;

    wb_exp_t wb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    pipe_forward_chain #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .STAGES   (STAGES),
        .NREAD    (NREAD),
        .LATE_STG (LATE_STG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .late_data (late_data),
        .flush_vec (flush_vec),
        .raddr     (raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .fwd_stall (fwd_stall),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] data, input logic rdy,
                         input logic retires, input logic [DATA_W-1:0] wb_exp_data);
        wb_exp_t e;
        in_valid = 1'b1;
        in_we    = we;
        in_rd    = rd;
        in_data  = data;
        in_rdy   = rdy;
        if (retires) begin
            e.rd   = rd;
            e.data = wb_exp_data;
            e.we   = we;
            wb_q.push_back(e);
        end
    endtask

    task automatic lookup(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a0);
        raddr = {a1, a0};
        #1;
    endtask

    // A retirement is new only if the previous edge actually advanced stage STAGES-1.
    always @(posedge clk) begin
        logic moved;
        wb_exp_t e;
        moved = !rst && !hold && !flush_vec[STAGES-1];
        #2;
        if (moved && wb_valid) begin
            if (wb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no retirement", wb_rd, wb_data);
            end else begin
                e = wb_q.pop_front();
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_data", 64'(wb_data), 64'(e.data));
                check("wb_we", 64'(wb_we), 64'(e.we));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        lookup(5'd5, 5'd3);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_we", 64'(wb_we), 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        check("rst_fwd_stall", 64'(fwd_stall), 64'd0);
        check("rst_fwd_data", 64'(fwd_data), 64'd0);

        // ALU forwarding, youngest writer wins
        issue(1'b1, 5'd8, 32'h11, 1'b1, 1'b1, 32'h11);
        tick();
        issue(1'b1, 5'd8, 32'h22, 1'b1, 1'b1, 32'h22);
        tick();
        lookup(5'd0, 5'd8);
        check("alu_hit", 64'(fwd_hit), 64'b01);
        check("alu_data", 64'(fwd_data[31:0]), 64'h22);
        check("alu_stall", 64'(fwd_stall), 64'd0);
        tick();
        tick();
        tick();

        // Load-use: stall in stage 0, late data captured entering stage 1
        issue(1'b1, 5'd9, 32'h0, 1'b0, 1'b1, 32'hCAFE);
        tick();
        lookup(5'd0, 5'd9);
        check("load_hit0", 64'(fwd_hit), 64'b01);
        check("load_stall0", 64'(fwd_stall), 64'b01);
        late_data = 32'hCAFE;
        tick();
        late_data = 32'h0;
        check("load_hit1", 64'(fwd_hit), 64'b01);
        check("load_stall1", 64'(fwd_stall), 64'd0);
        check("load_data1", 64'(fwd_data[31:0]), 64'hCAFE);
        tick();
        tick();

        // Register 0 and non-writers never hit
        issue(1'b1, 5'd0, 32'h55, 1'b1, 1'b1, 32'h55);
        tick();
        issue(1'b0, 5'd4, 32'h66, 1'b1, 1'b1, 32'h66);
        tick();
        lookup(5'd4, 5'd0);
        check("nohit_r0_r4", 64'(fwd_hit), 64'd0);
        check("nohit_data", 64'(fwd_data), 64'd0);
        tick();
        tick();
        tick();

        // Flush of stage 1 during hold; B never retires, A retires after release
        issue(1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 32'h0);
        tick();
        issue(1'b1, 5'd1, 32'hA1, 1'b1, 1'b1, 32'hA1);
        tick();
        hold      = 1'b1;
        flush_vec = 3'b010;
        in_valid  = 1'b1;
        in_we     = 1'b1;
        in_rd     = 5'd7;
        in_data   = 32'h77;
        in_rdy    = 1'b1;
        @(posedge clk);
        #1;
        flush_vec = '0;
        in_valid  = 1'b0;
        lookup(5'd1, 5'd2);
        check("flush_hit", 64'(fwd_hit), 64'b10);
        check("flush_keep_a", 64'(fwd_data[63:32]), 64'hA1);
        tick();
        lookup(5'd7, 5'd1);
        check("hold_ignores_in", 64'(fwd_hit), 64'b01);
        hold = 1'b0;
        tick();
        tick();
        tick();

        // Mid-run reset clears all stages
        issue(1'b1, 5'd10, 32'h10, 1'b1, 1'b1, 32'h10);
        tick();
        issue(1'b1, 5'd11, 32'h1011, 1'b1, 1'b0, 32'h0);
        tick();
        issue(1'b1, 5'd12, 32'h1012, 1'b1, 1'b0, 32'h0);
        tick();
        lookup(5'd12, 5'd11);
        check("pre_rst_hit", 64'(fwd_hit), 64'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lookup(5'd12, 5'd11);
        check("post_rst_hit", 64'(fwd_hit), 64'd0);
        check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
        tick();
        tick();
        check("scoreboard_drained", 64'(wb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
